// File: rtl/pb_uart_tx_if.sv
// kcpsm6 output-bus signals seen by the UART transmitter, plus its serial line
// and the status byte returned to the processor.
interface pb_uart_tx_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       tx;
  logic [7:0] status;

  modport master (
    output port_id, out_port, write_strobe,
    input  tx, status
  );

  modport slave (
    input  port_id, out_port, write_strobe,
    output tx, status
  );
endinterface

// File: rtl/pb_uart_tx.sv
// PicoBlaze output-port UART transmitter: 4-entry byte FIFO feeding an 8N1
// serialiser, with a pollable status byte.
module pb_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  DATA_PORT    = 8'h05,
  parameter logic [7:0]  CTRL_PORT    = 8'h06
) (
  input  logic        clk,
  input  logic        reset,
  pb_uart_tx_if.slave bus
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic [1:0]    head_q, head_d;
  logic [1:0]    tail_q, tail_d;
  logic [2:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [4];

  logic push_sel, push, drop, clr, pop, full, empty, busy, baud_last;

  assign full      = (count_q == 3'd4);
  assign empty     = (count_q == 3'd0);
  assign busy      = (state_q != IDLE);
  assign baud_last = (baud_q == BAUD_LAST);

  // full is taken from the registered count, so a same-cycle pop never rescues a push
  assign push_sel = bus.write_strobe && (bus.port_id == DATA_PORT);
  assign push     = push_sel && !full;
  assign drop     = push_sel && full;
  assign clr      = bus.write_strobe && (bus.port_id == CTRL_PORT) && bus.out_port[0];

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = mem_q[head_q];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        baud_d = baud_q + 1'b1;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + 1'b1;
        if (baud_last) begin
          baud_d = '0;
          sh_d   = {1'b0, sh_q[7:1]};
          bit_d  = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        baud_d = baud_q + 1'b1;
        if (baud_last) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            sh_d    = mem_q[head_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is derived from the next state so tx is a clean register output
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    head_d  = head_q + {1'b0, pop};
    tail_d  = tail_q + {1'b0, push};
    count_d = count_q + {2'b00, push} - {2'b00, pop};
    ovf_d   = ovf_q;
    if (drop)     ovf_d = 1'b1;
    else if (clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= bus.out_port;
  end

  assign bus.tx     = tx_q;
  assign bus.status = {1'b0, count_q, ovf_q, busy, full, empty};

endmodule

// File: tb/tb_pb_uart_tx.sv
// Randomised bench for pb_uart_tx: a frame-position model of the UART is
// compared against tx and status every cycle, with literal checks pinning it.
module tb_pb_uart_tx;
  localparam int C = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   go = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  pb_uart_tx_if ifc();

  pb_uart_tx #(.CLKS_PER_BIT(C), .DATA_PORT(8'h05), .CTRL_PORT(8'h06)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // Model: queue of waiting bytes, current byte, cycle offset inside its frame
  logic [7:0] q[$];
  logic [7:0] sent[$];
  logic [7:0] cur = '0;
  int         pos = -1;
  bit         ovf = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      pos = -1;
      ovf = 1'b0;
    end else begin
      automatic bit ps  = ifc.write_strobe && ifc.port_id == 8'h05;
      automatic bit cl  = ifc.write_strobe && ifc.port_id == 8'h06 && ifc.out_port[0];
      automatic int pre = q.size();
      automatic bit take = 1'b0;
      if (pos < 0) begin
        if (pre > 0) take = 1'b1;
      end else if (pos == 10*C - 1) begin
        if (pre > 0) take = 1'b1;
        else pos = -1;
      end else begin
        pos++;
      end
      if (take) begin
        cur = q.pop_front();
        pos = 0;
        sent.push_back(cur);
      end
      if (ps) begin
        if (pre == 4) ovf = 1'b1;
        else q.push_back(ifc.out_port);
      end else if (cl) begin
        ovf = 1'b0;
      end
    end
  end

  function automatic logic exp_tx();
    int idx;
    if (pos < 0) return 1'b1;
    idx = pos / C;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return cur[idx-1];
  endfunction

  function automatic logic [7:0] exp_status();
    int n = q.size();
    return {1'b0, 3'(n), ovf, pos >= 0, n == 4, n == 0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (go) begin
      chk("tx", {31'd0, ifc.tx}, {31'd0, exp_tx()});
      chk("status", {24'd0, ifc.status}, {24'd0, exp_status()});
    end
  end

  task automatic wr(input logic [7:0] p, input logic [7:0] d, input bit s);
    ifc.port_id      = p;
    ifc.out_port     = d;
    ifc.write_strobe = s;
    @(negedge clk);
    ifc.write_strobe = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (ifc.status != 8'h01 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_timeout", {31'd0, g < 2000}, 32'd1);
  endtask

  initial begin
    logic samp[40];
    int   exp_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    logic [7:0] pushed[$];
    int   n, g, lows;

    ifc.port_id = '0;
    ifc.out_port = '0;
    ifc.write_strobe = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    go = 1'b1;
    chk("reset_status", {24'd0, ifc.status}, 32'h01);
    chk("reset_tx", {31'd0, ifc.tx}, 32'd1);
    repeat (3) @(negedge clk);

    // Single byte: start bit 2 clocks after the strobe edge, 40-cycle frame
    wr(8'h05, 8'hA5, 1'b1);
    chk("lat_tx_high", {31'd0, ifc.tx}, 32'd1);
    chk("lat_count1", {24'd0, ifc.status}, 32'h10);
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      samp[k] = ifc.tx;
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("a5_bit%0d_first", i), {31'd0, samp[i*C]}, exp_bits[i]);
      chk($sformatf("a5_bit%0d_last", i), {31'd0, samp[i*C+C-1]}, exp_bits[i]);
    end
    chk("a5_idle_status", {24'd0, ifc.status}, 32'h01);

    // Back-to-back frames keep busy high for exactly 3 frames
    n = 0;
    wr(8'h05, 8'h01, 1'b1);
    wr(8'h05, 8'h02, 1'b1);
    if (ifc.status[2]) n++;
    wr(8'h05, 8'h03, 1'b1);
    g = 0;
    while (ifc.status[2] && g < 400) begin
      n++;
      g++;
      @(negedge clk);
    end
    chk("b2b_busy_cycles", n, 32'd120);
    wait_idle();

    // Port decode: nothing here may push
    foreach (exp_bits[i]) if (i < 1) begin end
    wr(8'h01, 8'h11, 1'b1);
    wr(8'h02, 8'h22, 1'b1);
    wr(8'h03, 8'h33, 1'b1);
    wr(8'h04, 8'h44, 1'b1);
    wr(8'h07, 8'h77, 1'b1);
    wr(8'h05, 8'h55, 1'b0);
    @(negedge clk);
    chk("decode_status", {24'd0, ifc.status}, 32'h01);

    // Overflow: 6 consecutive pushes, one popped, four fill, one dropped
    sent.delete();
    for (int i = 0; i < 5; i++) wr(8'h05, 8'h10 + 8'(i), 1'b1);
    chk("ovf_full", {24'd0, ifc.status}, 32'h46);
    wr(8'h05, 8'h15, 1'b1);
    chk("ovf_set", {24'd0, ifc.status}, 32'h4E);
    wr(8'h06, 8'h01, 1'b1);
    chk("ovf_clear", {24'd0, ifc.status}, 32'h46);
    wait_idle();
    chk("ovf_sent_n", sent.size(), 32'd5);
    for (int i = 0; i < 5 && i < sent.size(); i++)
      chk($sformatf("ovf_sent%0d", i), {24'd0, sent[i]}, 32'h10 + i);

    // Reset during DATA bit 3 with two bytes still queued
    wr(8'h05, 8'hC3, 1'b1);
    wr(8'h05, 8'h3C, 1'b1);
    wr(8'h05, 8'h99, 1'b1);
    g = 0;
    while (pos != 17 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("rst_reach_bit3", {31'd0, g < 200}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_tx", {31'd0, ifc.tx}, 32'd1);
    chk("rst_status", {24'd0, ifc.status}, 32'h01);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (!ifc.tx) lows++;
    end
    chk("rst_no_frames", lows, 32'd0);
    sent.delete();
    wr(8'h05, 8'h5A, 1'b1);
    wait_idle();
    chk("rst_5a_sent", {24'd0, sent.size() > 0 ? sent[0] : 8'h00}, 32'h5A);

    // Pointer wrap: 9 random bytes, never more than 4 outstanding
    sent.delete();
    for (int i = 0; i < 9; i++) begin
      automatic logic [7:0] b = 8'($urandom);
      repeat ($urandom_range(0, 50)) @(negedge clk);
      g = 0;
      while (q.size() >= 3 && g < 500) begin
        @(negedge clk);
        g++;
      end
      pushed.push_back(b);
      wr(8'h05, b, 1'b1);
    end
    wait_idle();
    chk("wrap_n", sent.size(), 32'd9);
    for (int i = 0; i < 9 && i < sent.size(); i++)
      chk($sformatf("wrap%0d", i), {24'd0, sent[i]}, {24'd0, pushed[i]});

    // Random soak over data, control and stray ports
    for (int i = 0; i < 1500; i++) begin
      automatic int sel = $urandom_range(0, 5);
      automatic logic [7:0] p = (sel < 3) ? 8'h05 : (sel == 3) ? 8'h06 : 8'($urandom);
      wr(p, 8'($urandom), $urandom_range(0, 2) == 0);
    end
    wr(8'h06, 8'h01, 1'b1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
